// File: rtl/regfile_dump.sv
// Debug readout engine: halts the pipeline, reads every register through a spare
// read port and streams them out over valid/ready. Optional checksum beat: REGFILE_DUMP_CSUM_EN.
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic [4:0]      ra,
  input  logic [XLEN-1:0] rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);
  localparam logic [4:0] CSUM_IDX = 5'd31;

  state_t          r_state;
  state_t          w_next;
  logic [4:0]      r_idx;
  logic [XLEN-1:0] r_data;
  logic [4:0]      r_out_idx;
  logic            r_last;
  logic            r_abort;

  logic            w_lost_ack;
  logic            w_xfer;
  logic            w_capture;
  logic            w_is_last_reg;
  logic            w_to_csum;
  logic            w_last_on_read;
  logic [XLEN-1:0] w_csum;

  // Losing the halt acknowledge while touching the register file voids the dump.
  assign w_lost_ack    = ((r_state == S_READ) || (r_state == S_SEND)) && !halt_ack;
  assign w_xfer        = (r_state == S_SEND) && halt_ack && out_ready;
  assign w_capture     = (r_state == S_READ) && halt_ack;
  assign w_is_last_reg = (r_idx == LAST_IDX);

`ifdef REGFILE_DUMP_CSUM_EN
  logic [XLEN-1:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (r_state == S_IDLE) begin
      r_csum <= '0;
    end else if (w_capture) begin
      r_csum <= r_csum ^ rd;
    end
  end

  // Last register beat is never final: the checksum beat follows straight from SEND.
  assign w_csum         = r_csum;
  assign w_to_csum      = w_xfer && !r_last && w_is_last_reg;
  assign w_last_on_read = 1'b0;
`else
  assign w_csum         = '0;
  assign w_to_csum      = 1'b0;
  assign w_last_on_read = w_is_last_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_HALT;
      S_HALT: if (halt_ack) w_next = S_READ;
      S_READ: w_next = halt_ack ? S_SEND : S_IDLE;
      S_SEND: begin
        if (!halt_ack) begin
          w_next = S_IDLE;
        end else if (out_ready) begin
          if (r_last) begin
            w_next = S_DONE;
          end else if (w_to_csum) begin
            w_next = S_SEND;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_data    <= '0;
      r_out_idx <= '0;
      r_last    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= w_lost_ack;

      if ((r_state == S_IDLE) && start) begin
        r_idx <= '0;
      end else if (w_xfer && !r_last && !w_to_csum) begin
        r_idx <= r_idx + 5'd1;
      end

      if (w_capture) begin
        r_data    <= rd;
        r_out_idx <= r_idx;
        r_last    <= w_last_on_read;
      end else if (w_to_csum) begin
        r_data    <= w_csum;
        r_out_idx <= CSUM_IDX;
        r_last    <= 1'b1;
      end
    end
  end

  assign ra        = (r_state == S_READ) ? r_idx : 5'd0;
  assign busy      = (r_state != S_IDLE);
  assign halt_req  = (r_state != S_IDLE);
  // Gating with halt_ack keeps a beat from slipping out on the abort cycle.
  assign out_valid = (r_state == S_SEND) && halt_ack;
  assign out_data  = r_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_last;
  assign abort     = r_abort;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: register-file model, delayed halt acknowledge,
// expected beat stream computed from register contents.
`timescale 1ns/1ps
module tb_regfile_dump;

  localparam int NREGS = 32;
  localparam int XLEN  = 64;
`ifdef REGFILE_DUMP_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int NBEATS = NREGS + (CSUM ? 1 : 0);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            halt_req;
  logic            halt_ack;
  logic [4:0]      ra;
  logic [XLEN-1:0] rd;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            abort;

  logic [XLEN-1:0] rf [NREGS];
  logic            ack_d1 = 1'b0;
  logic            ack_d2 = 1'b0;
  logic            ack_kill = 1'b0;

  logic [XLEN+5:0] rx_q [$];
  logic [XLEN+5:0] exp_q [$];

  int n_checks;
  int n_pass;
  int th, fv, lx, ab_cnt, unstable;
  logic pre_hr, first_hr, first_busy, hr1, hr2;
  bit timed_out;

  regfile_dump #(.NREGS(NREGS), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  // Pipeline model: acknowledges the halt two cycles after it is requested.
  always @(posedge clk) begin
    ack_d1 <= halt_req;
    ack_d2 <= ack_d1;
  end
  assign halt_ack = ack_d2 & ~ack_kill;
  assign rd = rf[ra];

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic preload_index();
    for (int i = 0; i < NREGS; i++) rf[i] = (i == 31) ? '0 : XLEN'(i);
  endtask

  task automatic preload_random();
    for (int i = 0; i < NREGS; i++) rf[i] = {$urandom, $urandom};
  endtask

  // Expected stream: each register in order, then the XOR of all of them if enabled.
  task automatic build_exp();
    logic [XLEN-1:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) begin
      x = x ^ rf[i];
      exp_q.push_back({rf[i], 5'(i), (i == NREGS - 1) && !CSUM});
    end
    if (CSUM) exp_q.push_back({x, 5'd31, 1'b1});
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_dump(input int mode, input bit hold);
    int cyc;
    bit fin, stall_pend;
    logic [XLEN-1:0] hd;
    logic [4:0] hi;
    logic hl;
    rx_q.delete();
    th = -1; fv = -1; lx = -1; ab_cnt = 0; unstable = 0;
    hr1 = 1'b0; hr2 = 1'b1; fin = 0; stall_pend = 0; cyc = 0;
    hd = '0; hi = '0; hl = 1'b0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; out_ready = ready_for(mode, 0);
    @(negedge clk); pre_hr = halt_req;
    @(posedge clk); #1; start = hold;
    while (!fin && cyc < 400) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin first_hr = halt_req; first_busy = busy; end
      if (th < 0 && halt_req && halt_ack) th = cyc;
      if (abort) ab_cnt++;
      if (out_valid && fv < 0) fv = cyc;
      if (stall_pend && (!out_valid || out_data !== hd || out_idx !== hi || out_last !== hl))
        unstable++;
      stall_pend = 0;
      if (out_valid && out_ready) begin
        rx_q.push_back({out_data, out_idx, out_last});
        if (out_last) lx = cyc;
      end else if (out_valid) begin
        stall_pend = 1; hd = out_data; hi = out_idx; hl = out_last;
      end
      if (lx > 0 && cyc == lx + 1) hr1 = halt_req;
      if (lx > 0 && cyc == lx + 2) begin hr2 = halt_req; fin = 1; end
      if (!fin) begin @(posedge clk); #1; out_ready = ready_for(mode, cyc); end
    end
    timed_out = !fin;
    $display("dump mode=%0d beats=%0d th=%0d first_valid=%0d last_xfer=%0d", mode, rx_q.size(), th, fv, lx);
  endtask

  task automatic test_reset();
    preload_index();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({halt_req, out_valid, out_last, busy, abort} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {halt_req, out_valid, out_last, busy, abort}); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_data got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_idx !== 5'd0) $display("FAIL reset_idx got %0d want 0", out_idx); else n_pass++;
    n_checks++; if (ra !== 5'd0) $display("FAIL reset_ra got %0d want 0", ra); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    preload_index();
    build_exp();
    run_dump(0, 1'b0);
    n_checks++; if (timed_out) $display("FAIL basic_timeout got timeout want done"); else n_pass++;
    n_checks++; if (pre_hr !== 1'b0) $display("FAIL basic_pre_halt got %b want 0", pre_hr); else n_pass++;
    n_checks++; if ({first_hr, first_busy} !== 2'b11)
      $display("FAIL basic_halt_busy got %b want 11", {first_hr, first_busy}); else n_pass++;
    n_checks++; if (fv != th + 2) $display("FAIL basic_first_valid got %0d want %0d", fv, th + 2); else n_pass++;
    n_checks++; if (lx != th + 2 * NREGS + (CSUM ? 1 : 0))
      $display("FAIL basic_last_xfer got %0d want %0d", lx, th + 2 * NREGS + (CSUM ? 1 : 0)); else n_pass++;
    n_checks++; if ({hr1, hr2} !== 2'b10) $display("FAIL basic_halt_fall got %b want 10", {hr1, hr2}); else n_pass++;
    n_checks++; if (ab_cnt != 0) $display("FAIL basic_abort got %0d want 0", ab_cnt); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size())
      $display("FAIL basic_count got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL basic_beat%0d got d=%h i=%0d l=%b want d=%h i=%0d l=%b", i, rx_q[i][XLEN+5:6],
                 rx_q[i][5:1], rx_q[i][0], exp_q[i][XLEN+5:6], exp_q[i][5:1], exp_q[i][0]);
      else n_pass++;
    end
`ifdef REGFILE_DUMP_CSUM_EN
    if (rx_q.size() > NREGS) begin
      n_checks++; if (rx_q[NREGS] !== {64'h1F, 5'd31, 1'b1})
        $display("FAIL csum_beat got %h want 1f/31/1", rx_q[NREGS]); else n_pass++;
      n_checks++; if (rx_q[NREGS-1][0] !== 1'b0)
        $display("FAIL csum_reg31_last got %b want 0", rx_q[NREGS-1][0]); else n_pass++;
    end
`endif
  endtask

  task automatic test_stall();
    preload_index();
    build_exp();
    run_dump(1, 1'b0);
    n_checks++; if (timed_out) $display("FAIL stall_timeout got timeout want done"); else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL stall_stable got %0d want 0", unstable); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size())
      $display("FAIL stall_count got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL stall_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int cyc, got, extra_ab, extra_v;
    bit seen;
    preload_index();
    got = 0; seen = 0; cyc = 0; extra_ab = 0; extra_v = 0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk); cyc++;
      if (out_valid && out_idx == 5'd10) seen = 1;
      else if (out_valid && out_ready) got++;
    end
    n_checks++; if (!seen) $display("FAIL abort_reach got timeout want beat10"); else n_pass++;
    ack_kill = 1'b1;
    @(negedge clk);
    n_checks++; if ({abort, out_valid, halt_req, busy} !== 4'b1000)
      $display("FAIL abort_next got %b want 1000", {abort, out_valid, halt_req, busy}); else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (abort) extra_ab++;
      if (out_valid) extra_v++;
    end
    n_checks++; if (extra_ab != 0) $display("FAIL abort_pulse got %0d extra want 0", extra_ab); else n_pass++;
    n_checks++; if (extra_v != 0) $display("FAIL abort_beats got %0d extra want 0", extra_v); else n_pass++;
    n_checks++; if (got != 10) $display("FAIL abort_sent got %0d want 10", got); else n_pass++;
    $display("abort after %0d beats", got);
    ack_kill = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    preload_index();
    seen = 0; cyc = 0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk); cyc++;
      if (out_valid && out_idx == 5'd5) seen = 1;
    end
    n_checks++; if (!seen) $display("FAIL rstmid_reach got timeout want beat5"); else n_pass++;
    #2; rst_n = 1'b0;
    #1;
    n_checks++; if ({halt_req, out_valid, out_last, busy, abort} !== 5'b0)
      $display("FAIL rstmid_flags got %b want 00000", {halt_req, out_valid, out_last, busy, abort}); else n_pass++;
    n_checks++; if ({out_data, out_idx, ra} !== '0)
      $display("FAIL rstmid_data got d=%h i=%0d ra=%0d want 0", out_data, out_idx, ra); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    build_exp();
    run_dump(0, 1'b0);
    n_checks++; if (timed_out) $display("FAIL rstmid_timeout got timeout want done"); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size())
      $display("FAIL rstmid_count got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL rstmid_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_start_held();
    int cyc;
    preload_index();
    build_exp();
    run_dump(0, 1'b1);
    n_checks++; if (timed_out) $display("FAIL held_timeout got timeout want done"); else n_pass++;
    n_checks++; if (rx_q.size() != NBEATS)
      $display("FAIL held_count got %0d want %0d", rx_q.size(), NBEATS); else n_pass++;
    n_checks++; if (hr2 !== 1'b0) $display("FAIL held_idle got %b want 0", hr2); else n_pass++;
    @(negedge clk);
    n_checks++; if (halt_req !== 1'b1) $display("FAIL held_restart got %b want 1", halt_req); else n_pass++;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin @(negedge clk); cyc++; end
    n_checks++; if (busy !== 1'b0) $display("FAIL held_drain got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      preload_random();
      build_exp();
      run_dump(2, 1'b0);
      n_checks++; if (timed_out) $display("FAIL rand%0d_timeout got timeout want done", r); else n_pass++;
      n_checks++; if (unstable != 0) $display("FAIL rand%0d_stable got %0d want 0", r, unstable); else n_pass++;
      n_checks++; if (rx_q.size() != exp_q.size())
        $display("FAIL rand%0d_count got %0d want %0d", r, rx_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (rx_q[i] !== exp_q[i]) $display("FAIL rand%0d_beat%0d got %h want %h", r, i, rx_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_reset_mid();
    test_start_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
